// File: rtl/bcd_seg_mux.sv
//------------------------------------------------------------------------------
// Module      : bcd_seg_mux
// Description : Two-digit BCD to 7-segment time-multiplexed display driver.
//               Optional macro BCD_SEG_MUX_LZB_EN enables tens-digit
//               leading-zero blanking.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_seg_mux #(
  parameter int DIV = 50000
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       LD,
  input  logic [3:0] Qz,
  input  logic [3:0] Qu,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       ERR,
  output logic       TICK
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(DIV - 1);

  typedef enum logic {
    S_UNITS = 1'b0,
    S_TENS  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    tz_q, tz_d, tu_q, tu_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          err_q, err_d;
  logic          tick_q, tick_d;
  logic          slot_end;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b1001111;
    endcase
    return s;
  endfunction

  assign slot_end = (cnt_q == C_CNT_LAST);

  // Prescaler and slot FSM run independently of the snapshot path.
  always_comb begin
    cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    if (slot_end) begin
      state_d = (state_q == S_UNITS) ? S_TENS : S_UNITS;
    end
  end

  always_comb begin
    tz_d = tz_q;
    tu_d = tu_q;
    if (LD) begin
      tz_d = Qz;
      tu_d = Qu;
    end
  end

  // Outputs reflect the state and snapshot held before the edge.
  always_comb begin
    tick_d = slot_end;
    err_d  = (tz_q > 4'd9) | (tu_q > 4'd9);
    if (state_q == S_TENS) begin
      an_d  = 2'b10;
      seg_d = seg_decode(tz_q);
    end else begin
      an_d  = 2'b01;
      seg_d = seg_decode(tu_q);
    end
`ifdef BCD_SEG_MUX_LZB_EN
    if ((state_q == S_TENS) && (tz_q == 4'd0)) begin
      an_d  = 2'b00;
      seg_d = 7'b0000000;
    end
`endif
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_UNITS;
      cnt_q   <= '0;
      tz_q    <= 4'd0;
      tu_q    <= 4'd0;
      seg_q   <= 7'b0000000;
      an_q    <= 2'b00;
      err_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tz_q    <= tz_d;
      tu_q    <= tu_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      err_q   <= err_d;
      tick_q  <= tick_d;
    end
  end

  assign SEG  = seg_q;
  assign AN   = an_q;
  assign ERR  = err_q;
  assign TICK = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_seg_mux.sv
//------------------------------------------------------------------------------
// Module      : tb_bcd_seg_mux
// Description : Scoreboard bench for bcd_seg_mux (DIV=4), directed + random.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_seg_mux;

  localparam int DIV = 4;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic       LD = 1'b0;
  logic [3:0] Qz = 4'd0;
  logic [3:0] Qu = 4'd0;
  logic [6:0] SEG;
  logic [1:0] AN;
  logic       ERR;
  logic       TICK;

  bcd_seg_mux #(.DIV(DIV)) dut (
    .CK(CK), .RST(RST), .LD(LD), .Qz(Qz), .Qu(Qu),
    .SEG(SEG), .AN(AN), .ERR(ERR), .TICK(TICK)
  );

  always #5 CK = ~CK;

  logic [6:0] segtab [16];
  initial begin
    segtab[0] = 7'b1111110; segtab[1] = 7'b0110000; segtab[2] = 7'b1101101;
    segtab[3] = 7'b1111001; segtab[4] = 7'b0110011; segtab[5] = 7'b1011011;
    segtab[6] = 7'b1011111; segtab[7] = 7'b1110000; segtab[8] = 7'b1111111;
    segtab[9] = 7'b1111011;
    for (int i = 10; i < 16; i++) segtab[i] = 7'b1001111;
  end

  // Expected {SEG, AN, ERR, TICK} after each driven edge.
  logic [10:0] exp_q [$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // Model: m = non-reset edges since the last reset edge.
  int m = 0;
  int mtz = 0;
  int mtu = 0;

  task automatic step(input logic rst, input logic ld, input int qz, input int qu);
    logic [6:0] s;
    logic [1:0] a;
    logic e, t;
    int slot, dig;
    @(negedge CK);
    RST = rst; LD = ld; Qz = 4'(qz); Qu = 4'(qu);
    if (rst) begin
      exp_q.push_back(11'd0);
      m = 0; mtz = 0; mtu = 0;
    end else begin
      slot = (m / DIV) % 2;
      t = ((m % DIV) == DIV - 1);
      e = (mtz > 9) || (mtu > 9);
      dig = (slot == 1) ? mtz : mtu;
      s = segtab[dig];
      a = (slot == 1) ? 2'b10 : 2'b01;
`ifdef BCD_SEG_MUX_LZB_EN
      if (slot == 1 && mtz == 0) begin
        s = 7'b0000000;
        a = 2'b00;
      end
`endif
      exp_q.push_back({s, a, e, t});
      if (ld) begin
        mtz = qz;
        mtu = qu;
      end
      m++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15));
  endtask

  // Advance until the next edge is at prescaler phase ph in slot st (0=units).
  task automatic align(input int ph, input int st);
    while (!((m % DIV) == ph && ((m / DIV) % 2) == st)) idle(1);
  endtask

  always @(posedge CK) begin
    logic [10:0] e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if ({SEG, AN, ERR, TICK} !== e) begin
        mismatched++;
        $display("FAIL outputs cycle %0d: got SEG=%b AN=%b ERR=%b TICK=%b, expected SEG=%b AN=%b ERR=%b TICK=%b",
                 cyc, SEG, AN, ERR, TICK, e[10:4], e[3:2], e[1], e[0]);
      end
    end
  end

  initial begin
    logic hold;
    int hq_z, hq_u;
    // Reset state
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 5, 5);
    // Idle alternation after release
    idle(12);
    // 47 display
    step(1'b0, 1'b1, 4, 7);
    idle(10);
    // Non-BCD units -> ERR, then cleared
    step(1'b0, 1'b1, 3, 12);
    idle(9);
    step(1'b0, 1'b1, 3, 5);
    idle(4);
    // LD on a units->tens boundary edge
    align(DIV - 1, 0);
    step(1'b0, 1'b1, 9, 9);
    idle(6);
    // Zero tens digit
    step(1'b0, 1'b1, 0, 5);
    idle(10);
    // Reset mid-slot in TENS with snapshot 81, reset beats LD
    step(1'b0, 1'b1, 8, 1);
    align(2, 1);
    step(1'b1, 1'b1, 6, 6);
    idle(10);
    // Reset coinciding with a boundary
    align(DIV - 1, 1);
    step(1'b1, 1'b0, 0, 0);
    idle(5);
    // Randomised traffic, including long LD-held stretches
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) hold = ~hold;
      hq_z = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
      hq_u = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
      step(($urandom_range(0, 59) == 0), hold || ($urandom_range(0, 5) == 0), hq_z, hq_u);
    end
    idle(2);
    repeat (3) @(posedge CK);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
